// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline hazard control: load-use stall, MULT/DIV HI/LO interlock, branch flush
// Optional HAZARD_STATS_EN adds saturating stall_cycles / flush_cycles outputs.
module hazard_stall_ctrl #(
   parameter int REG_W        = 5,
   parameter int MULDIV_LAT   = 32,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] rs_ID,
   input  logic [REG_W-1:0] rt_ID,
   input  logic             uses_rs_ID,
   input  logic             uses_rt_ID,
   input  logic             muldiv_ID,
   input  logic             hilo_use_ID,
   input  logic             memread_EX,
   input  logic [REG_W-1:0] rt_EX,
   input  logic             branch_taken_EX,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             muldiv_busy,
   output logic [1:0]       hazard_state
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]      stall_cycles,
   output logic [31:0]      flush_cycles
`endif
);

   localparam int MD_W = $clog2(MULDIV_LAT + 1);
   localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} stateT;

   stateT           state, stateNext;
   logic [FL_W-1:0] flushCnt, flushCntNext;
   logic [MD_W-1:0] mdCnt, mdCntNext;
   logic            flush, loadUse, mdStall, stall, issue;

   always_comb begin
      flush   = branch_taken_EX | (state == FLUSH);
      loadUse = memread_EX & (rt_EX != '0) &
                ((uses_rs_ID & (rs_ID == rt_EX)) | (uses_rt_ID & (rt_ID == rt_EX)));
      mdStall = (mdCnt != '0) & (muldiv_ID | hilo_use_ID);
      stall   = ~flush & (loadUse | mdStall);
      issue   = muldiv_ID & ~stall & ~flush & (mdCnt == '0);
   end

   // A taken branch (re)arms the extra flush cycles; the branch cycle itself is the first one.
   always_comb begin
      stateNext    = state;
      flushCntNext = flushCnt;
      if (branch_taken_EX && (FLUSH_CYCLES > 1)) begin
         stateNext    = FLUSH;
         flushCntNext = FL_W'(FLUSH_CYCLES - 1);
      end else if (state == FLUSH) begin
         flushCntNext = flushCnt - FL_W'(1);
         if (flushCnt <= FL_W'(1)) begin
            stateNext = RUN;
         end
      end
   end

   always_comb begin
      mdCntNext = mdCnt;
      if (issue) begin
         mdCntNext = MD_W'(MULDIV_LAT);
      end else if (mdCnt != '0) begin
         mdCntNext = mdCnt - MD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= RUN;
         flushCnt <= '0;
         mdCnt    <= '0;
      end else begin
         state    <= stateNext;
         flushCnt <= flushCntNext;
         mdCnt    <= mdCntNext;
      end
   end

   always_comb begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      muldiv_busy  = (mdCnt != '0);
      hazard_state = {flush, mdCnt != '0};
      if (!rst_n) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         ifid_flush   = 1'b1;
         idex_bubble  = 1'b1;
         muldiv_busy  = 1'b0;
         hazard_state = 2'b00;
      end else if (flush) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (stall) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] stallCycles, flushCycles;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stallCycles <= '0;
         flushCycles <= '0;
      end else begin
         if (stall && (stallCycles != 32'hFFFF_FFFF)) begin
            stallCycles <= stallCycles + 32'd1;
         end
         if (flush && (flushCycles != 32'hFFFF_FFFF)) begin
            flushCycles <= flushCycles + 32'd1;
         end
      end
   end

   assign stall_cycles = stallCycles;
   assign flush_cycles = flushCycles;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
// Built with MULDIV_LAT=4 and FLUSH_CYCLES=2; stats outputs checked when HAZARD_STATS_EN is defined.
module tb_hazard_stall_ctrl;

   logic       clk;
   logic       rst_n;
   logic [4:0] rs_ID, rt_ID, rt_EX;
   logic       uses_rs_ID, uses_rt_ID, muldiv_ID, hilo_use_ID, memread_EX, branch_taken_EX;
   logic       pc_write, ifid_write, ifid_flush, idex_bubble, muldiv_busy;
   logic [1:0] hazard_state;
   logic [3:0] ctl;
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cycles, flush_cycles;
`endif

   int passed = 0;
   int total  = 0;

   hazard_stall_ctrl #(.REG_W(5), .MULDIV_LAT(4), .FLUSH_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rs_ID(uses_rs_ID), .uses_rt_ID(uses_rt_ID),
      .muldiv_ID(muldiv_ID), .hilo_use_ID(hilo_use_ID),
      .memread_EX(memread_EX), .rt_EX(rt_EX), .branch_taken_EX(branch_taken_EX),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .muldiv_busy(muldiv_busy), .hazard_state(hazard_state)
`ifdef HAZARD_STATS_EN
      , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
   );

   // {pc_write, ifid_write, ifid_flush, idex_bubble}: run=1100 stall=0001 flush=1111 reset=0011
   assign ctl = {pc_write, ifid_write, ifid_flush, idex_bubble};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      rs_ID = 5'd0; rt_ID = 5'd0; rt_EX = 5'd0;
      uses_rs_ID = 1'b0; uses_rt_ID = 1'b0; muldiv_ID = 1'b0; hilo_use_ID = 1'b0;
      memread_EX = 1'b0; branch_taken_EX = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      tick();
      #1;
      total++;
      if (ctl !== 4'b0011) $display("FAIL reset_ctl: got %b want %b", ctl, 4'b0011); else passed++;
      total++;
      if ({muldiv_busy, hazard_state} !== 3'b000)
         $display("FAIL reset_state: got %b want %b", {muldiv_busy, hazard_state}, 3'b000);
      else passed++;
      tick();
      rst_n = 1'b1;
      #1;
      total++;
      if (ctl !== 4'b1100) $display("FAIL idle_run: got %b want %b", ctl, 4'b1100); else passed++;
   endtask

   task automatic test_load_use();
      memread_EX = 1'b1; rt_EX = 5'd5; uses_rs_ID = 1'b1; rs_ID = 5'd5;
      #1;
      total++;
      if (ctl !== 4'b0001) $display("FAIL load_use_rs: got %b want %b", ctl, 4'b0001); else passed++;
      tick();
      memread_EX = 1'b0; rt_EX = 5'd0;
      #1;
      total++;
      if (ctl !== 4'b1100) $display("FAIL load_use_release: got %b want %b", ctl, 4'b1100); else passed++;
      clear_inputs();
      memread_EX = 1'b1; rt_EX = 5'd7; rs_ID = 5'd7; rt_ID = 5'd7; uses_rt_ID = 1'b1;
      #1;
      total++;
      if (ctl !== 4'b0001) $display("FAIL load_use_rt: got %b want %b", ctl, 4'b0001); else passed++;
      uses_rt_ID = 1'b0;
      #1;
      total++;
      if (ctl !== 4'b1100) $display("FAIL load_use_unused_regs: got %b want %b", ctl, 4'b1100); else passed++;
      uses_rs_ID = 1'b1; memread_EX = 1'b0;
      #1;
      total++;
      if (ctl !== 4'b1100) $display("FAIL no_load_no_stall: got %b want %b", ctl, 4'b1100); else passed++;
      uses_rs_ID = 1'b1; memread_EX = 1'b1; rs_ID = 5'd6;
      #1;
      total++;
      if (ctl !== 4'b1100) $display("FAIL load_other_reg: got %b want %b", ctl, 4'b1100); else passed++;
      clear_inputs();
      tick();
   endtask

   task automatic test_zero_reg();
      memread_EX = 1'b1; rt_EX = 5'd0; rs_ID = 5'd0; uses_rs_ID = 1'b1; rt_ID = 5'd0; uses_rt_ID = 1'b1;
      #1;
      total++;
      if (ctl !== 4'b1100) $display("FAIL zero_reg_no_stall: got %b want %b", ctl, 4'b1100); else passed++;
      clear_inputs();
      tick();
   endtask

   task automatic test_muldiv();
      muldiv_ID = 1'b1;
      #1;
      total++;
      if (ctl !== 4'b1100 || muldiv_busy !== 1'b0)
         $display("FAIL muldiv_issue: got %b/%b want %b/0", ctl, muldiv_busy, 4'b1100);
      else passed++;
      tick();
      muldiv_ID = 1'b0; hilo_use_ID = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if (ctl !== 4'b0001 || hazard_state !== 2'b01)
            $display("FAIL hilo_stall_%0d: got %b/%b want %b/01", i, ctl, hazard_state, 4'b0001);
         else passed++;
         tick();
      end
      total++;
      if (ctl !== 4'b1100 || muldiv_busy !== 1'b0)
         $display("FAIL hilo_release: got %b/%b want %b/0", ctl, muldiv_busy, 4'b1100);
      else passed++;
      clear_inputs();
      tick();
   endtask

   task automatic test_back_to_back_muldiv();
      int stalls;
      muldiv_ID = 1'b1;
      tick();
      stalls = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (ctl == 4'b0001) begin
            stalls++;
            tick();
         end
      end
      total++;
      if (stalls != 4) $display("FAIL b2b_stall_count: got %0d want 4", stalls); else passed++;
      total++;
      if (ctl !== 4'b1100 || muldiv_busy !== 1'b0)
         $display("FAIL b2b_second_issue: got %b/%b want %b/0", ctl, muldiv_busy, 4'b1100);
      else passed++;
      tick();
      muldiv_ID = 1'b0;
      #1;
      total++;
      if (muldiv_busy !== 1'b1) $display("FAIL b2b_busy_after_issue: got %b want 1", muldiv_busy); else passed++;
      repeat (4) tick();
      total++;
      if (muldiv_busy !== 1'b0) $display("FAIL b2b_drain: got %b want 0", muldiv_busy); else passed++;
   endtask

   task automatic test_flush();
      branch_taken_EX = 1'b1;
      #1;
      total++;
      if (ctl !== 4'b1111 || hazard_state !== 2'b10)
         $display("FAIL flush_cycle0: got %b/%b want %b/10", ctl, hazard_state, 4'b1111);
      else passed++;
      tick();
      branch_taken_EX = 1'b0;
      #1;
      total++;
      if (ctl !== 4'b1111 || hazard_state !== 2'b10)
         $display("FAIL flush_cycle1: got %b/%b want %b/10", ctl, hazard_state, 4'b1111);
      else passed++;
      tick();
      total++;
      if (ctl !== 4'b1100 || hazard_state !== 2'b00)
         $display("FAIL flush_end: got %b/%b want %b/00", ctl, hazard_state, 4'b1100);
      else passed++;
   endtask

   task automatic test_flush_vs_load_use();
      memread_EX = 1'b1; rt_EX = 5'd9; rs_ID = 5'd9; uses_rs_ID = 1'b1; branch_taken_EX = 1'b1;
      #1;
      total++;
      if (ctl !== 4'b1111) $display("FAIL flush_beats_stall: got %b want %b", ctl, 4'b1111); else passed++;
      tick();
      branch_taken_EX = 1'b0;
      #1;
      total++;
      if (ctl !== 4'b1111) $display("FAIL flush_state_beats_stall: got %b want %b", ctl, 4'b1111); else passed++;
      tick();
      total++;
      if (ctl !== 4'b0001) $display("FAIL stall_after_flush: got %b want %b", ctl, 4'b0001); else passed++;
      clear_inputs();
      tick();
   endtask

   task automatic test_flush_reload();
      branch_taken_EX = 1'b1;
      tick();
      tick();
      branch_taken_EX = 1'b0;
      #1;
      total++;
      if (ctl !== 4'b1111) $display("FAIL flush_reload: got %b want %b", ctl, 4'b1111); else passed++;
      tick();
      total++;
      if (ctl !== 4'b1100) $display("FAIL flush_reload_end: got %b want %b", ctl, 4'b1100); else passed++;
   endtask

   task automatic test_flush_keeps_muldiv();
      muldiv_ID = 1'b1; branch_taken_EX = 1'b1;
      tick();
      branch_taken_EX = 1'b0; muldiv_ID = 1'b0;
      #1;
      total++;
      if (muldiv_busy !== 1'b0) $display("FAIL no_issue_in_flush: got %b want 0", muldiv_busy); else passed++;
      tick();
      muldiv_ID = 1'b1;
      tick();
      muldiv_ID = 1'b0; branch_taken_EX = 1'b1;
      #1;
      total++;
      if (hazard_state !== 2'b11) $display("FAIL flush_with_busy: got %b want 11", hazard_state); else passed++;
      tick();
      branch_taken_EX = 1'b0;
      tick();
      hilo_use_ID = 1'b1;
      #1;
      total++;
      if (ctl !== 4'b0001 || muldiv_busy !== 1'b1)
         $display("FAIL muldiv_survives_flush: got %b/%b want %b/1", ctl, muldiv_busy, 4'b0001);
      else passed++;
      tick();
      tick();
      total++;
      if (ctl !== 4'b1100) $display("FAIL muldiv_done_after_flush: got %b want %b", ctl, 4'b1100); else passed++;
      clear_inputs();
   endtask

   task automatic test_reset_mid_op();
      muldiv_ID = 1'b1;
      tick();
      muldiv_ID = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      #1;
      total++;
      if (muldiv_busy !== 1'b0 || hazard_state !== 2'b00)
         $display("FAIL reset_mid_op: got %b/%b want 0/00", muldiv_busy, hazard_state);
      else passed++;
`ifdef HAZARD_STATS_EN
      total++;
      if (stall_cycles !== 32'd0 || flush_cycles !== 32'd0)
         $display("FAIL stats_reset: got %0d/%0d want 0/0", stall_cycles, flush_cycles);
      else passed++;
`endif
      rst_n = 1'b1; hilo_use_ID = 1'b1;
      #1;
      total++;
      if (ctl !== 4'b1100) $display("FAIL muldiv_abandoned: got %b want %b", ctl, 4'b1100); else passed++;
      clear_inputs();
      branch_taken_EX = 1'b1;
      tick();
      branch_taken_EX = 1'b0; rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      total++;
      if (ctl !== 4'b1100) $display("FAIL flush_abandoned: got %b want %b", ctl, 4'b1100); else passed++;
   endtask

`ifdef HAZARD_STATS_EN
   task automatic test_stats();
      memread_EX = 1'b1; rt_EX = 5'd3; rs_ID = 5'd3; uses_rs_ID = 1'b1;
      tick();
      clear_inputs();
      branch_taken_EX = 1'b1;
      tick();
      branch_taken_EX = 1'b0;
      tick();
      total++;
      if (stall_cycles !== 32'd1 || flush_cycles !== 32'd2)
         $display("FAIL stats_count: got %0d/%0d want 1/2", stall_cycles, flush_cycles);
      else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_load_use();
      test_zero_reg();
      test_muldiv();
      test_back_to_back_muldiv();
      test_flush();
      test_flush_vs_load_use();
      test_flush_reload();
      test_flush_keeps_muldiv();
      test_reset_mid_op();
`ifdef HAZARD_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
